// File: rtl/core_pkg.sv
// Shared fetch-side types: FSM state encoding, queue entry layout and the NOP filler word.
package core_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit boundary: imem request/response, redirect input and the IF/ID output stage.
interface fetch_unit_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_4;
  logic [31:0] out_inst;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  redirect_valid,
    input  redirect_pc,
    input  stall,
    output out_valid,
    output out_pc,
    output out_pc_plus_4,
    output out_inst
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_resp_valid,
    output imem_resp_data,
    output redirect_valid,
    output redirect_pc,
    output stall,
    input  out_valid,
    input  out_pc,
    input  out_pc_plus_4,
    input  out_inst
  );

endinterface

// File: rtl/fetch_queue.sv
// In-order fetch queue (registered storage, head read straight from the array); push-to-head 1 cycle.
// Clear beats push/pop; push when full and pop when empty are ignored, the caller's credits prevent both.
module fetch_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign head    = mem[rd_ptr];

  // Payload needs no reset: nothing reads it while count says empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: credit-limited sequential PC fetch into an in-order queue; response reaches out_* 1 cycle later.
// stall freezes the queue head; requests stop once outstanding + queued reaches FQ_DEPTH.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam logic [CW:0] CREDIT_LIM = FQ_DEPTH[CW:0];

  fetch_state_e  state;
  logic [31:0]   fpc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] occupancy;
  logic [CW:0]   credits_used;
  logic          req_fire;
  logic          q_push;
  logic          q_pop;
  logic          q_empty;
  fetch_entry_t  q_in;
  fetch_entry_t  q_head;

  assign credits_used = {1'b0, outstanding} + {1'b0, occupancy};

  assign bus.imem_req_valid = !rst && (state == RUN) && !bus.redirect_valid
                              && (credits_used < CREDIT_LIM);
  assign bus.imem_req_addr  = word_align(fpc);
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // resp_pc tracks the PC of the oldest live request, so responses carry no tag.
  assign q_push = (state == RUN) && bus.imem_resp_valid && !bus.redirect_valid;
  assign q_pop  = !q_empty && !bus.stall && !bus.redirect_valid;
  assign q_in   = '{pc: resp_pc, pc_plus_4: resp_pc + 32'd4, inst: bus.imem_resp_data};

  always_comb begin
    outstanding_nxt = outstanding;
    if (req_fire && !bus.imem_resp_valid) begin
      outstanding_nxt = outstanding + 1'b1;
    end else if (!req_fire && bus.imem_resp_valid && (outstanding != '0)) begin
      outstanding_nxt = outstanding - 1'b1;
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (bus.redirect_valid),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .head      (q_head),
    .empty     (q_empty),
    .count     (occupancy)
  );

  assign bus.out_valid     = !q_empty;
  assign bus.out_pc        = q_empty ? 32'h0 : q_head.pc;
  assign bus.out_pc_plus_4 = q_empty ? 32'h0 : q_head.pc_plus_4;
  assign bus.out_inst      = q_empty ? NOP_INST : q_head.inst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      fpc         <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (req_fire) begin
        fpc <= fpc + 32'd4;
      end
      case (state)
        RUN: begin
          if (bus.redirect_valid) begin
            // Everything still in flight belongs to the old path and gets dropped in FLUSH.
            fpc         <= bus.redirect_pc;
            resp_pc     <= bus.redirect_pc;
            outstanding <= '0;
            drop_cnt    <= outstanding_nxt;
            state       <= (outstanding_nxt != '0) ? FLUSH : RUN;
          end else begin
            outstanding <= outstanding_nxt;
            if (bus.imem_resp_valid) begin
              resp_pc <= resp_pc + 32'd4;
            end
          end
        end
        FLUSH: begin
          if (bus.redirect_valid) begin
            fpc     <= bus.redirect_pc;
            resp_pc <= bus.redirect_pc;
          end
          if (bus.imem_resp_valid && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - 1'b1;
          end
          if ((drop_cnt == '0) || ((drop_cnt == 1) && bus.imem_resp_valid)) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fixed-latency memory model plus in-order check on every pop.
module tb_fetch_unit;
  import core_pkg::*;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic  clk;
  logic  rst;
  int    checks;
  int    errors;
  int    cyc;
  int    lat;
  logic [31:0] exp_pc;
  pend_t pend[$];

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .FQ_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed no finish, required finish");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: check any pop against the expected PC stream, log accepted requests,
  // then present the response that falls due in the new cycle.
  task automatic cycle();
    pend_t p;
    @(negedge clk);
    if (!rst && !bus.redirect_valid && (bus.out_valid === 1'b1) && !bus.stall) begin
      chk("order_pc", bus.out_pc, exp_pc);
      chk("order_inst", bus.out_inst, mem_word(exp_pc));
      chk("order_pc4", bus.out_pc_plus_4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
    end
    if ((bus.imem_req_valid === 1'b1) && bus.imem_req_ready) begin
      p.addr = bus.imem_req_addr;
      p.due  = cyc + lat;
      pend.push_back(p);
    end
    @(posedge clk);
    #1;
    cyc++;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    if ((pend.size() > 0) && (pend[0].due <= cyc)) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.stall          = 1'b0;
    lat                = 1;
    cycle();
    cycle();
    pend.delete();
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    #1;
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_inst", bus.out_inst, 32'h0000_0013);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_pc4", bus.out_pc_plus_4, 32'h0);
    rst    = 1'b0;
    exp_pc = 32'h0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    lat    = 1;
    exp_pc = 32'h0;
    rst    = 1'b1;
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.stall           = 1'b0;

    // Boot sequence with 1-cycle memory
    do_reset();
    #1;
    chk("boot_req_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("boot_addr", bus.imem_req_addr, 32'h0);
    chk("boot_out_valid", 32'(bus.out_valid), 32'h0);
    cycle(); #1;
    chk("c1_req_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("c1_addr", bus.imem_req_addr, 32'h4);
    chk("c1_out_valid", 32'(bus.out_valid), 32'h0);
    cycle(); #1;
    chk("c2_out_valid", 32'(bus.out_valid), 32'h1);
    chk("c2_out_pc", bus.out_pc, 32'h0);
    chk("c2_out_inst", bus.out_inst, 32'h1357_9BDF);
    chk("c2_out_pc4", bus.out_pc_plus_4, 32'h4);
    chk("c2_credit_block", 32'(bus.imem_req_valid), 32'h0);
    cycle(); #1;
    chk("c3_out_pc", bus.out_pc, 32'h4);
    chk("c3_req_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("c3_addr", bus.imem_req_addr, 32'h8);

    // Stall held 5 cycles: head frozen, credits exhausted after one more request
    bus.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_out_valid", 32'(bus.out_valid), 32'h1);
      chk("stall_out_pc", bus.out_pc, 32'h4);
      if (i > 0) chk("stall_no_req", 32'(bus.imem_req_valid), 32'h0);
      cycle();
    end
    bus.stall = 1'b0;
    repeat (12) cycle();
    #1;
    chk("resume_pops", exp_pc, 32'h24);
    chk("resume_out_pc", bus.out_pc, 32'h24);

    // Redirect with two responses in flight (latency 4), second redirect while flushing
    do_reset();
    lat = 4;
    #1;
    chk("fl_addr0", bus.imem_req_addr, 32'h0);
    cycle();
    cycle(); #1;
    chk("fl_credit_full", 32'(bus.imem_req_valid), 32'h0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    exp_pc             = 32'h80;
    cycle();
    bus.redirect_pc = 32'h100;
    exp_pc          = 32'h100;
    #1;
    chk("fl_redirect_gate", 32'(bus.imem_req_valid), 32'h0);
    cycle();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("fl_no_req", 32'(bus.imem_req_valid), 32'h0);
      chk("fl_dropped", 32'(bus.out_valid), 32'h0);
      cycle();
    end
    #1;
    chk("fl_run_req", 32'(bus.imem_req_valid), 32'h1);
    chk("fl_run_addr", bus.imem_req_addr, 32'h100);
    chk("fl_run_empty", 32'(bus.out_valid), 32'h0);
    lat = 1;
    cycle(); #1;
    chk("fl_pre_out", 32'(bus.out_valid), 32'h0);
    cycle(); #1;
    chk("fl_out_valid", 32'(bus.out_valid), 32'h1);
    chk("fl_out_pc", bus.out_pc, 32'h100);
    chk("fl_out_inst", bus.out_inst, 32'h1357_9ADF);

    // Redirect in the same cycle as a response and a pop
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    exp_pc             = 32'h200;
    cycle();
    bus.redirect_valid = 1'b0;
    #1;
    chk("same_out_valid", 32'(bus.out_valid), 32'h0);
    chk("same_out_inst", bus.out_inst, 32'h0000_0013);
    chk("same_out_pc", bus.out_pc, 32'h0);
    chk("same_out_pc4", bus.out_pc_plus_4, 32'h0);
    chk("same_req_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("same_addr", bus.imem_req_addr, 32'h200);
    cycle();
    cycle(); #1;
    chk("same_new_pc", bus.out_pc, 32'h200);
    chk("same_new_inst", bus.out_inst, 32'h1357_99DF);

    // Memory not ready for 3 cycles, then redirect while the request waits
    do_reset();
    cycle();
    cycle();
    cycle();
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait_req_valid", 32'(bus.imem_req_valid), 32'h1);
      chk("wait_addr", bus.imem_req_addr, 32'h8);
      if (i < 2) cycle();
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h300;
    exp_pc             = 32'h300;
    #1;
    chk("wait_redirect_gate", 32'(bus.imem_req_valid), 32'h0);
    cycle();
    bus.redirect_valid = 1'b0;
    #1;
    chk("wait_new_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("wait_new_addr", bus.imem_req_addr, 32'h300);
    bus.imem_req_ready = 1'b1;
    cycle();
    cycle(); #1;
    chk("wait_out_pc", bus.out_pc, 32'h300);

    // PC wrap at the top of the address space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    exp_pc             = 32'hFFFF_FFFC;
    cycle();
    bus.redirect_valid = 1'b0;
    #1;
    chk("wrap_addr_top", bus.imem_req_addr, 32'hFFFF_FFFC);
    cycle(); #1;
    chk("wrap_addr_zero", bus.imem_req_addr, 32'h0);
    chk("wrap_req_valid", 32'(bus.imem_req_valid), 32'h1);
    cycle(); #1;
    chk("wrap_out_pc", bus.out_pc, 32'hFFFF_FFFC);
    chk("wrap_out_pc4", bus.out_pc_plus_4, 32'h0);
    chk("wrap_out_inst", bus.out_inst, 32'hECA8_6423);
    cycle(); #1;
    chk("wrap_next_pc", bus.out_pc, 32'h0);
    chk("wrap_next_pc4", bus.out_pc_plus_4, 32'h4);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter FQ_DEPTH, default 2, meaning the fetch-queue entry count (power of two, >=2).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port imem_req_valid  out  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_req_ready  in  1  memory accepts the request this cycle.
REQ-007 SHALL have port imem_req_addr  out  32  word-aligned fetch address.
REQ-008 SHALL have port imem_resp_valid  in  1  instruction word returned; in order, latency >=1, no backpressure.
REQ-009 SHALL have port imem_resp_data  in  32  returned instruction.
REQ-010 SHALL have port redirect_valid  in  1  branch/jump/exception redirect from later stages.
REQ-011 SHALL have port redirect_pc  in  32  redirect target.
REQ-012 SHALL have port stall  in  1  downstream (IF/ID register) not accepting this cycle.
REQ-013 SHALL have port out_valid  out  1  out_* hold a valid instruction for IF/ID.
REQ-014 SHALL have ports out_pc, out_pc_plus_4, out_inst  out  32 each  PC, PC+4, instruction of the queue head.

Function
REQ-015 SHALL keep fetch PC fpc; imem_req_addr = {fpc[31:2],2'b00}; fpc += 4 (mod 2^32, wraps) on each accepted request (valid && ready).
REQ-016 SHALL assert imem_req_valid only in state RUN, when redirect_valid=0, and when outstanding + queue occupancy < FQ_DEPTH (credit rule; queue never overflows).
REQ-017 SHALL hold imem_req_addr stable while imem_req_valid=1 and ready=0, except when a redirect changes fpc.
REQ-018 SHALL, on each imem_resp_valid in RUN, push {pc, pc+4, data} into the queue in request order; outstanding decrements.
REQ-019 SHALL drive out_* from the queue head with no combinational bypass; response at cycle T is visible at out_* at T+1.
REQ-020 SHALL pop the head when out_valid=1 and stall=0; push and pop in the same cycle keep occupancy unchanged.
REQ-021 SHALL drive out_valid=0, out_inst=32'h0000_0013 (NOP), out_pc=out_pc_plus_4=0 when the queue is empty.
REQ-022 SHALL implement states RUN and FLUSH; redirect_valid has priority over every other event in the cycle.
REQ-023 SHALL on redirect_valid: fpc<=redirect_pc, queue cleared (including any same-cycle push), same-cycle pop ignored, drop_cnt<=outstanding after this cycle's accepted request/response; next state FLUSH if drop_cnt>0, else RUN.
REQ-024 SHALL in FLUSH discard each imem_resp_valid and decrement drop_cnt; issue no requests; return to RUN the cycle after drop_cnt reaches 0.
REQ-025 SHALL treat a redirect during FLUSH as a fpc update only; drop_cnt unchanged.
REQ-026 SHALL never let outstanding exceed FQ_DEPTH; width = clog2(FQ_DEPTH+1).

Reset
REQ-027 SHALL on rst=1: fpc=RESET_PC, queue empty, outstanding=0, drop_cnt=0, state RUN, imem_req_valid=0, out_valid=0.
REQ-028 SHALL issue the first request the cycle after rst deasserts; reset mid-operation aborts everything, and responses to pre-reset requests are the bench's responsibility to suppress.

Structure
REQ-029 SHALL place fetch_state_e {RUN, FLUSH} and the NOP constant in shared package core_pkg.
REQ-030 SHALL implement the queue as sub-module fetch_queue (parameterized depth, push/pop/clear, synchronous-reset pointers).

Verification
REQ-031 Reset then 1-cycle-latency memory, stall=0 -> requests 0x0,0x4,0x8...; out_valid from cycle 3; out_pc 0x0,0x4 back-to-back.
REQ-032 stall=1 held 5 cycles -> at most 2 outstanding+queued; out_* frozen; no request while credits=0; resume in order, no loss.
REQ-033 Redirect to 0x100 with 2 responses in flight -> FLUSH; both responses dropped; next out_pc=0x100, out_inst=memory[0x100].
REQ-034 Redirect in same cycle as response and pop -> queue empty next cycle, out_valid=0, response discarded.
REQ-035 imem_req_ready=0 for 3 cycles -> address stable at 0x8; redirect mid-wait -> address becomes redirect_pc next cycle.
REQ-036 fpc=0xFFFF_FFFC -> next request addr 0x0000_0000; out_pc_plus_4=0x0000_0000.
